// File: rtl/lap_pkg.sv
// Shared types and constants for the Laplacian window scheduler.
// Tap indices follow the row-major window layout: byte k of win_o is tap k.
package lap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACCEPT  = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } lap_state_e;

    localparam int PIX_W    = 8;
    localparam int WIN_TAPS = 9;
    localparam int RES_W    = 9;

    localparam int TAP_TL = 0;
    localparam int TAP_TC = 1;
    localparam int TAP_TR = 2;
    localparam int TAP_ML = 3;
    localparam int CENTRE = 4;
    localparam int TAP_MR = 5;
    localparam int TAP_BL = 6;
    localparam int TAP_BC = 7;
    localparam int TAP_BR = 8;

endpackage

// File: rtl/lap_line_buf.sv
// One image line of pixel storage, single port, combinational read.
// A read and a write to the same address in one cycle returns the old value.
module lap_line_buf
    import lap_pkg::*;
#(
    parameter int DEPTH = 64,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [PIX_W-1:0] wdata_i,
    output logic [PIX_W-1:0] rdata_o
);

    // Contents are deliberately not reset: rows are always refilled before use.
    logic [PIX_W-1:0] mem_q [DEPTH];

    assign rdata_o = mem_q[addr_i];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/lap_window_sched.sv
// Raster-scan scheduler feeding 3x3 windows to the Laplacian filter datapath.
// Define LAPLACE_CLAMP_EN to clamp negative filter results to 0 instead of wrapping.
//
// Pixel handshake: a pixel transfers on a rising clk_i edge where pix_ready_o
// and pix_valid_i are both high; pix_ready_o is high only in ACCEPT and does not
// depend on pix_valid_i, so the source may stall or hold valid freely.
module lap_window_sched
    import lap_pkg::*;
#(
    parameter int IMG_W    = 64,
    parameter int IMG_H    = 64,
    parameter int FILT_LAT = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic                         pix_valid_i,
    input  logic [PIX_W-1:0]             pix_i,
    output logic                         pix_ready_o,
    output logic [WIN_TAPS*PIX_W-1:0]    win_o,
    output logic                         win_en_o,
    input  logic [RES_W-1:0]             filt_data_i,
    output logic                         res_valid_o,
    output logic [PIX_W-1:0]             res_o,
    output logic                         busy_o,
    output logic                         done_o,
    output lap_state_e                   dbg_state_o
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int LW = $clog2(FILT_LAT + 1);

    lap_state_e                      state_q, state_d;
    logic [CW-1:0]                   col_q, col_d;
    logic [RW-1:0]                   row_q, row_d;
    logic [LW-1:0]                   lat_q, lat_d;
    logic                            last_q, last_d;
    logic [WIN_TAPS-1:0][PIX_W-1:0]  win_q, win_d;
    logic [PIX_W-1:0]                res_q, res_d;
    logic                            res_valid_q, res_valid_d;
    logic [PIX_W-1:0]                res_map;
    logic [PIX_W-1:0]                lb0_rd, lb1_rd;
    logic                            accept, col_last, row_last, win_ready;

    assign accept    = (state_q == ST_ACCEPT) && pix_valid_i;
    assign col_last  = (col_q == CW'(IMG_W - 1));
    assign row_last  = (row_q == RW'(IMG_H - 1));
    assign win_ready = (row_q >= RW'(2)) && (col_q >= CW'(2));

    // lb0 holds the previous row, lb1 the row before that.
    lap_line_buf #(.DEPTH(IMG_W)) u_lb0 (
        .clk_i   (clk_i),
        .we_i    (accept),
        .addr_i  (col_q),
        .wdata_i (pix_i),
        .rdata_o (lb0_rd)
    );

    lap_line_buf #(.DEPTH(IMG_W)) u_lb1 (
        .clk_i   (clk_i),
        .we_i    (accept),
        .addr_i  (col_q),
        .wdata_i (lb0_rd),
        .rdata_o (lb1_rd)
    );

`ifdef LAPLACE_CLAMP_EN
    assign res_map = filt_data_i[RES_W-1] ? '0 : filt_data_i[PIX_W-1:0];
`else
    logic unused_sign;
    assign unused_sign = filt_data_i[RES_W-1];
    assign res_map     = filt_data_i[PIX_W-1:0];
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (start_i) state_d = ST_ACCEPT;
            ST_ACCEPT:  if (accept && win_ready) state_d = ST_ISSUE;
            ST_ISSUE:   if (lat_q == '0) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = last_q ? ST_DONE : ST_ACCEPT;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pix_ready_o = (state_q == ST_ACCEPT);
        win_en_o    = (state_q == ST_ISSUE);
        busy_o      = (state_q != ST_IDLE);
        done_o      = (state_q == ST_DONE);
        win_o       = win_q;
        res_o       = res_q;
        res_valid_o = res_valid_q;
        dbg_state_o = state_q;
    end

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        lat_d       = lat_q;
        last_d      = last_q;
        win_d       = win_q;
        res_d       = res_q;
        res_valid_d = 1'b0;
        if ((state_q == ST_IDLE) && start_i) begin
            col_d = '0;
            row_d = '0;
        end
        if (accept) begin
            win_d[TAP_TL] = win_q[TAP_TC];
            win_d[TAP_TC] = win_q[TAP_TR];
            win_d[TAP_TR] = lb1_rd;
            win_d[TAP_ML] = win_q[CENTRE];
            win_d[CENTRE] = win_q[TAP_MR];
            win_d[TAP_MR] = lb0_rd;
            win_d[TAP_BL] = win_q[TAP_BC];
            win_d[TAP_BC] = win_q[TAP_BR];
            win_d[TAP_BR] = pix_i;
            col_d  = col_last ? '0 : col_q + 1'b1;
            if (col_last) begin
                row_d = row_last ? '0 : row_q + 1'b1;
            end
            last_d = col_last && row_last;
            lat_d  = LW'(FILT_LAT - 1);
        end
        if ((state_q == ST_ISSUE) && (lat_q != '0)) begin
            lat_d = lat_q - 1'b1;
        end
        if (state_q == ST_CAPTURE) begin
            res_d       = res_map;
            res_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col_q       <= '0;
            row_q       <= '0;
            lat_q       <= '0;
            last_q      <= 1'b0;
            win_q       <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            lat_q       <= lat_d;
            last_q      <= last_d;
            win_q       <= win_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
        end
    end

endmodule

// File: tb/tb_lap_window_sched.sv
// Bench for lap_window_sched on a 4x4 frame with a 4-cycle filter stub.
// Expected windows/results come from a frame-level model over the pixel array.
module tb_lap_window_sched;
    import lap_pkg::*;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int F    = 4;
    localparam int NPIX = W * H;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        pix_valid_i = 1'b0;
    logic [7:0]  pix_i = 8'h00;
    logic        pix_ready_o;
    logic [71:0] win_o;
    logic        win_en_o;
    logic [8:0]  filt_data_i;
    logic        res_valid_o;
    logic [7:0]  res_o;
    logic        busy_o;
    logic        done_o;
    lap_state_e  dbg_state;

    always #5 clk = ~clk;

    lap_window_sched #(.IMG_W(W), .IMG_H(H), .FILT_LAT(F)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .pix_valid_i (pix_valid_i),
        .pix_i       (pix_i),
        .pix_ready_o (pix_ready_o),
        .win_o       (win_o),
        .win_en_o    (win_en_o),
        .filt_data_i (filt_data_i),
        .res_valid_o (res_valid_o),
        .res_o       (res_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .dbg_state_o (dbg_state)
    );

    int total = 0;
    int bad   = 0;

    // 8*centre minus the eight neighbours, saturated to signed 9 bits.
    function automatic logic [8:0] sat9(input int s);
        int v;
        v = s;
        if (v > 255)  v = 255;
        if (v < -256) v = -256;
        return v[8:0];
    endfunction

    function automatic logic [8:0] stub_lap(input logic [71:0] w);
        int s;
        s = 8 * int'(w[39:32]);
        for (int k = 0; k < 9; k++) if (k != 4) s = s - int'(w[k*8 +: 8]);
        return sat9(s);
    endfunction

    // Filter stub: result is only presented after exactly F enabled cycles.
    int         en_cnt;
    logic [8:0] held;
    always @(posedge clk) begin
        if (rst_i) en_cnt <= 0;
        else if (win_en_o) begin
            en_cnt <= en_cnt + 1;
            held   <= stub_lap(win_o);
        end else en_cnt <= 0;
    end
    assign filt_data_i = (en_cnt == F) ? held : 9'h1AB;

    // Frame model and expected queues.
    int          img [NPIX];
    logic [7:0]  exp_q[$];
    logic [71:0] exp_win_q[$];

    function automatic void build_expected();
        logic [71:0] w;
        int s, v;
        exp_q.delete();
        exp_win_q.delete();
        for (int r = 1; r <= H - 2; r++) begin
            for (int c = 1; c <= W - 2; c++) begin
                s = 0;
                for (int k = 0; k < 9; k++) begin
                    w[k*8 +: 8] = 8'(img[(r - 1 + k / 3) * W + (c - 1 + k % 3)]);
                    if (k != 4) s = s - img[(r - 1 + k / 3) * W + (c - 1 + k % 3)];
                end
                s = s + 8 * img[r * W + c];
                if (s > 255)  s = 255;
                if (s < -256) s = -256;
`ifdef LAPLACE_CLAMP_EN
                v = (s < 0) ? 0 : s;
`else
                v = s & 255;
`endif
                exp_q.push_back(8'(v));
                exp_win_q.push_back(w);
            end
        end
    endfunction

    // Monitor: samples on the falling edge.
    logic [7:0]  got_q[$];
    logic [71:0] got_win_q[$];
    int          en_len_q[$];
    logic [71:0] first_win;
    int cyc = 0, done_cnt, done_cyc, done_res_n, last_res_cyc, min_gap;
    int unstable, ready_bad, en_rises, en_run;
    bit prev_en = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (res_valid_o) begin
            got_q.push_back(res_o);
            if (last_res_cyc >= 0 && cyc - last_res_cyc < min_gap) min_gap = cyc - last_res_cyc;
            last_res_cyc = cyc;
        end
        if (done_o) begin
            done_cnt++;
            done_cyc   = cyc;
            done_res_n = got_q.size();
        end
        if (win_en_o) begin
            if (!prev_en) begin
                got_win_q.push_back(win_o);
                first_win = win_o;
                en_rises++;
                en_run = 1;
            end else begin
                en_run++;
                if (win_o !== first_win) unstable++;
            end
        end else if (prev_en) en_len_q.push_back(en_run);
        if (pix_ready_o && (win_en_o || prev_en || !busy_o || done_o)) ready_bad++;
        prev_en = win_en_o;
    end

    task automatic clear_mon();
        got_q.delete();
        got_win_q.delete();
        en_len_q.delete();
        done_cnt = 0; done_cyc = -1; done_res_n = -1;
        last_res_cyc = -1; min_gap = 1000000;
        unstable = 0; ready_bad = 0; en_rises = 0; en_run = 0;
    endtask

    // Driver: all input changes happen 1ns after the falling edge.
    int last_acc, drv_timeout, aborted;

    task automatic drive_frame(input bit stall, input int abort_win, input int start_at);
        int idx, budget;
        bit start_done;
        idx = 0; budget = 0; start_done = 0; drv_timeout = 0; aborted = 0;
        @(negedge clk); #1;
        start_i = 1'b1;
        while (idx < NPIX && budget < 2000) begin
            @(negedge clk); #1;
            budget++;
            start_i = 1'b0;
            if (start_at > 0 && idx == start_at && !start_done) begin
                start_i = 1'b1;
                start_done = 1;
            end
            if (abort_win > 0 && en_rises == abort_win && win_en_o) begin
                rst_i = 1'b1;
                pix_valid_i = 1'b0;
                aborted = 1;
                break;
            end
            if (stall && $urandom_range(0, 99) < 50) pix_valid_i = 1'b0;
            else begin
                pix_valid_i = 1'b1;
                pix_i = 8'(img[idx]);
                if (pix_ready_o) begin
                    idx++;
                    last_acc = cyc;
                end
            end
        end
        if (budget >= 2000) drv_timeout = 1;
        if (!aborted) begin
            @(negedge clk); #1;
            pix_valid_i = 1'b0;
            start_i = 1'b0;
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_cnt == 0 && n < 600) begin
            @(negedge clk); #1;
            n++;
        end
        repeat (2 * F + 6) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        total += 8;
        if (pix_ready_o !== 1'b0) begin bad++; $display("FAIL reset pix_ready got=%b exp=0", pix_ready_o); end
        if (win_en_o !== 1'b0)    begin bad++; $display("FAIL reset win_en got=%b exp=0", win_en_o); end
        if (res_valid_o !== 1'b0) begin bad++; $display("FAIL reset res_valid got=%b exp=0", res_valid_o); end
        if (busy_o !== 1'b0)      begin bad++; $display("FAIL reset busy got=%b exp=0", busy_o); end
        if (done_o !== 1'b0)      begin bad++; $display("FAIL reset done got=%b exp=0", done_o); end
        if (res_o !== 8'h00)      begin bad++; $display("FAIL reset res got=%h exp=00", res_o); end
        if (win_o !== 72'h0)      begin bad++; $display("FAIL reset win got=%h exp=0", win_o); end
        if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL reset state got=%0d exp=%0d", dbg_state, ST_IDLE); end
        rst_i = 1'b0;
        @(negedge clk); #1;
        total++;
        if (busy_o !== 1'b0) begin bad++; $display("FAIL idle_after_reset busy got=%b exp=0", busy_o); end
    endtask

    task automatic test_constant();
        for (int i = 0; i < NPIX; i++) img[i] = 10;
        build_expected();
        clear_mon();
        drive_frame(1'b0, 0, 0);
        wait_done();
        total += 6;
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL const count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        if (done_cnt != 1) begin bad++; $display("FAIL const done_count got=%0d exp=1", done_cnt); end
        if (done_res_n != exp_q.size()) begin bad++; $display("FAIL const done_order got=%0d exp=%0d", done_res_n, exp_q.size()); end
        if (last_res_cyc - last_acc != F + 2) begin bad++; $display("FAIL const latency got=%0d exp=%0d", last_res_cyc - last_acc, F + 2); end
        if (min_gap != F + 2) begin bad++; $display("FAIL const spacing got=%0d exp=%0d", min_gap, F + 2); end
        if (drv_timeout != 0) begin bad++; $display("FAIL const drive_timeout got=%0d exp=0", drv_timeout); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total += 2;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL const res[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
            if (i >= en_len_q.size() || en_len_q[i] != F) begin
                bad++; $display("FAIL const en_len[%0d] got=%0d exp=%0d", i, (i < en_len_q.size()) ? en_len_q[i] : -1, F);
            end
        end
    endtask

    task automatic test_ramp();
        for (int i = 0; i < NPIX; i++) img[i] = i;
        build_expected();
        clear_mon();
        drive_frame(1'b0, 0, 0);
        wait_done();
        total += 2;
        if (got_win_q.size() != exp_win_q.size()) begin bad++; $display("FAIL ramp win_count got=%0d exp=%0d", got_win_q.size(), exp_win_q.size()); end
        if (unstable != 0) begin bad++; $display("FAIL ramp win_stable got=%0d exp=0", unstable); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total += 2;
            if (i >= got_win_q.size() || got_win_q[i] !== exp_win_q[i]) begin
                bad++; $display("FAIL ramp win[%0d] got=%h exp=%h", i, (i < got_win_q.size()) ? got_win_q[i] : 72'hx, exp_win_q[i]);
            end
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL ramp res[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_bright_centre();
        for (int i = 0; i < NPIX; i++) img[i] = 0;
        img[1 * W + 1] = 100;
        build_expected();
        clear_mon();
        drive_frame(1'b0, 0, 0);
        wait_done();
        total++;
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL bright count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL bright res[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_random_stalls();
        for (int rep = 0; rep < 4; rep++) begin
            for (int i = 0; i < NPIX; i++) img[i] = $urandom_range(0, 255);
            build_expected();
            clear_mon();
            drive_frame(1'b1, 0, 0);
            wait_done();
            total += 4;
            if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL stall count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
            if (ready_bad != 0) begin bad++; $display("FAIL stall ready_outside_accept got=%0d exp=0", ready_bad); end
            if (done_cnt != 1) begin bad++; $display("FAIL stall done_count got=%0d exp=1", done_cnt); end
            if (unstable != 0) begin bad++; $display("FAIL stall win_stable got=%0d exp=0", unstable); end
            for (int i = 0; i < exp_q.size(); i++) begin
                total += 2;
                if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                    bad++; $display("FAIL stall res[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
                end
                if (i >= got_win_q.size() || got_win_q[i] !== exp_win_q[i]) begin
                    bad++; $display("FAIL stall win[%0d] got=%h exp=%h", i, (i < got_win_q.size()) ? got_win_q[i] : 72'hx, exp_win_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_issue();
        for (int i = 0; i < NPIX; i++) img[i] = $urandom_range(0, 255);
        clear_mon();
        drive_frame(1'b0, 2, 0);
        total++;
        if (aborted != 1) begin bad++; $display("FAIL midreset reached_issue2 got=%0d exp=1", aborted); end
        @(negedge clk); #1;
        total += 8;
        if (pix_ready_o !== 1'b0) begin bad++; $display("FAIL midreset pix_ready got=%b exp=0", pix_ready_o); end
        if (win_en_o !== 1'b0)    begin bad++; $display("FAIL midreset win_en got=%b exp=0", win_en_o); end
        if (res_valid_o !== 1'b0) begin bad++; $display("FAIL midreset res_valid got=%b exp=0", res_valid_o); end
        if (busy_o !== 1'b0)      begin bad++; $display("FAIL midreset busy got=%b exp=0", busy_o); end
        if (done_o !== 1'b0)      begin bad++; $display("FAIL midreset done got=%b exp=0", done_o); end
        if (res_o !== 8'h00)      begin bad++; $display("FAIL midreset res got=%h exp=00", res_o); end
        if (win_o !== 72'h0)      begin bad++; $display("FAIL midreset win got=%h exp=0", win_o); end
        if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL midreset state got=%0d exp=%0d", dbg_state, ST_IDLE); end
        rst_i = 1'b0;
        repeat (3 * F) @(negedge clk);
        #1;
        total += 2;
        if (done_cnt != 0) begin bad++; $display("FAIL midreset no_done got=%0d exp=0", done_cnt); end
        if (got_q.size() != 1) begin bad++; $display("FAIL midreset partial_results got=%0d exp=1", got_q.size()); end
        for (int i = 0; i < NPIX; i++) img[i] = $urandom_range(0, 255);
        build_expected();
        clear_mon();
        drive_frame(1'b0, 0, 0);
        wait_done();
        total += 2;
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL after_reset count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        if (done_cnt != 1) begin bad++; $display("FAIL after_reset done_count got=%0d exp=1", done_cnt); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL after_reset res[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_start_mid_frame();
        for (int i = 0; i < NPIX; i++) img[i] = $urandom_range(0, 255);
        build_expected();
        clear_mon();
        drive_frame(1'b0, 0, 9);
        wait_done();
        total += 3;
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL midstart count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        if (done_cnt != 1) begin bad++; $display("FAIL midstart done_count got=%0d exp=1", done_cnt); end
        if (done_cyc - last_acc != F + 2) begin bad++; $display("FAIL midstart done_timing got=%0d exp=%0d", done_cyc - last_acc, F + 2); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL midstart res[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int fr = 0; fr < 2; fr++) begin
            for (int i = 0; i < NPIX; i++) img[i] = $urandom_range(0, 255);
            build_expected();
            clear_mon();
            drive_frame(1'b0, 0, 0);
            wait_done();
            total += 2;
            if (done_cnt != 1) begin bad++; $display("FAIL b2b done_count got=%0d exp=1", done_cnt); end
            if (ready_bad != 0) begin bad++; $display("FAIL b2b ready_outside_accept got=%0d exp=0", ready_bad); end
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                    bad++; $display("FAIL b2b res[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_constant();
        test_ramp();
        test_bright_centre();
        test_random_stalls();
        test_reset_mid_issue();
        test_start_mid_frame();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog sim_time got=expired exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
